// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: default operand formats, derived full-resolution
// widths, a constant max() and the two's-complement saturation constants.
package fxp_pkg;

  function automatic int fxp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEF_NB_IN_A     = 16;
  localparam int DEF_NBF_IN_A    = 14;
  localparam int DEF_NB_IN_B     = 12;
  localparam int DEF_NBF_IN_B    = 11;
  localparam int DEF_NB_OUT      = 11;
  localparam int DEF_NBF_OUT     = 10;
  localparam int DEF_NB_O_ROUND  = 9;
  localparam int DEF_NBF_O_ROUND = 8;
  localparam int DEF_NB_CNT      = 8;

  // One extra integer bit makes A - B exact for any operand pair.
  localparam int NBI_A    = DEF_NB_IN_A - DEF_NBF_IN_A;
  localparam int NBI_B    = DEF_NB_IN_B - DEF_NBF_IN_B;
  localparam int NBI_O_FR = fxp_max(NBI_A, NBI_B) + 1;
  localparam int NBF_O_FR = fxp_max(DEF_NBF_IN_A, DEF_NBF_IN_B);
  localparam int NB_O_FR  = NBI_O_FR + NBF_O_FR;

  function automatic logic [63:0] sat_pos(input int nb);
    return (64'd1 << (nb - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int nb);
    return 64'd1 << (nb - 1);
  endfunction

endpackage

// File: rtl/fxp_sat_resize.sv
// Signed MSB-drop with saturation: keeps the low NB_OUT bits when the dropped
// bits are pure sign extension, otherwise clamps to max/min and flags it.
module fxp_sat_resize
  import fxp_pkg::*;
#(
  parameter int NB_IN  = 13,
  parameter int NB_OUT = 11
) (
  input  logic [NB_IN-1:0]  i_data,
  output logic [NB_OUT-1:0] o_data,
  output logic              o_sat
);

  localparam logic [NB_OUT-1:0] POS_MAX = NB_OUT'(sat_pos(NB_OUT));
  localparam logic [NB_OUT-1:0] NEG_MIN = NB_OUT'(sat_neg(NB_OUT));

  logic [NB_IN-NB_OUT:0] msbs;

  always_comb begin
    msbs  = i_data[NB_IN-1:NB_OUT-1];
    o_sat = !((&msbs) || (~|msbs));
    if (!o_sat)               o_data = i_data[NB_OUT-1:0];
    else if (i_data[NB_IN-1]) o_data = NEG_MIN;
    else                      o_data = POS_MAX;
  end

endmodule

// File: rtl/fxp_sub_pipe.sv
// Three-stage fixed-point subtractor A - B with full-resolution, truncated and
// rounded saturating outputs, valid/ready flow control and saturation debug.
module fxp_sub_pipe
  import fxp_pkg::*;
#(
  parameter int NB_IN_A     = DEF_NB_IN_A,
  parameter int NBF_IN_A    = DEF_NBF_IN_A,
  parameter int NB_IN_B     = DEF_NB_IN_B,
  parameter int NBF_IN_B    = DEF_NBF_IN_B,
  parameter int NB_OUT      = DEF_NB_OUT,
  parameter int NBF_OUT     = DEF_NBF_OUT,
  parameter int NB_O_ROUND  = DEF_NB_O_ROUND,
  parameter int NBF_O_ROUND = DEF_NBF_O_ROUND,
  parameter int NB_CNT      = DEF_NB_CNT,
  localparam int FR_NBF = fxp_max(NBF_IN_A, NBF_IN_B),
  localparam int FR_NB  = fxp_max(NB_IN_A - NBF_IN_A, NB_IN_B - NBF_IN_B) + 1 + FR_NBF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NB_IN_A-1:0]    i_A,
  input  logic [NB_IN_B-1:0]    i_B,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [FR_NB-1:0]      o_diffFR,
  output logic [NB_OUT-1:0]     o_diff_trunc_sat,
  output logic [NB_O_ROUND-1:0] o_diff_round_sat,
  output logic                  o_sat_trunc,
  output logic                  o_sat_round,
  input  logic                  i_clr,
  output logic                  o_sat_sticky,
  output logic [NB_CNT-1:0]     o_sat_cnt
);

  localparam int SH_A  = FR_NBF - NBF_IN_A;
  localparam int SH_B  = FR_NBF - NBF_IN_B;
  localparam int SH_T  = FR_NBF - NBF_OUT;
  localparam int TR_NB = FR_NB - SH_T;
  localparam int SH_R  = FR_NBF - NBF_O_ROUND;
  localparam int RS_NB = FR_NB + 1;
  localparam int RD_NB = RS_NB - SH_R;
  localparam logic signed [RS_NB-1:0] HALF = RS_NB'(1) <<< (SH_R - 1);

  logic                    en;
  logic signed [FR_NB-1:0] a_ext, b_ext;
  logic [TR_NB-1:0]        tr_in;
  logic [NB_OUT-1:0]       tr_sat;
  logic                    tr_flag;
  logic signed [RS_NB-1:0] rs_full;
  logic [NB_O_ROUND-1:0]   rd_sat;
  logic                    rd_flag;
  logic                    sat_evt;

  logic [2:0]              vld_q, vld_d;
  logic signed [FR_NB-1:0] fr1_q, fr1_d, fr2_q, fr2_d, fr3_q, fr3_d;
  logic [NB_OUT-1:0]       tr2_q, tr2_d, tr3_q, tr3_d;
  logic                    st2_q, st2_d, st3_q, st3_d;
  logic [RD_NB-1:0]        rs2_q, rs2_d;
  logic [NB_O_ROUND-1:0]   rd3_q, rd3_d;
  logic                    sr3_q, sr3_d;
  logic [NB_CNT-1:0]       cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;

  fxp_sat_resize #(.NB_IN(TR_NB), .NB_OUT(NB_OUT)) u_trunc (
    .i_data (tr_in),
    .o_data (tr_sat),
    .o_sat  (tr_flag)
  );

  fxp_sat_resize #(.NB_IN(RD_NB), .NB_OUT(NB_O_ROUND)) u_round (
    .i_data (rs2_q),
    .o_data (rd_sat),
    .o_sat  (rd_flag)
  );

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    en       = ~vld_q[2] | i_ready;
    a_ext    = FR_NB'($signed(i_A)) <<< SH_A;
    b_ext    = FR_NB'($signed(i_B)) <<< SH_B;
    tr_in    = TR_NB'(fr1_q >>> SH_T);
    rs_full  = RS_NB'(fr1_q) + HALF;
    sat_evt  = vld_q[2] & i_ready & (st3_q | sr3_q);

    vld_d    = vld_q;
    fr1_d    = fr1_q;
    fr2_d    = fr2_q;
    fr3_d    = fr3_q;
    tr2_d    = tr2_q;
    tr3_d    = tr3_q;
    st2_d    = st2_q;
    st3_d    = st3_q;
    rs2_d    = rs2_q;
    rd3_d    = rd3_q;
    sr3_d    = sr3_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    // One shared enable: a stalled output freezes the whole pipe.
    if (en) begin
      vld_d = {vld_q[1:0], i_valid};
      fr1_d = a_ext - b_ext;
      fr2_d = fr1_q;
      tr2_d = tr_sat;
      st2_d = tr_flag;
      rs2_d = RD_NB'(rs_full >>> SH_R);
      fr3_d = fr2_q;
      tr3_d = tr2_q;
      st3_d = st2_q;
      rd3_d = rd_sat;
      sr3_d = rd_flag;
    end

    if (i_clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (sat_evt) begin
      sticky_d = 1'b1;
      if (~&cnt_q) cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  // NOTE: data registers are reset too, so outputs read as zero right after reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vld_q    <= '0;
      fr1_q    <= '0;
      fr2_q    <= '0;
      fr3_q    <= '0;
      tr2_q    <= '0;
      tr3_q    <= '0;
      st2_q    <= 1'b0;
      st3_q    <= 1'b0;
      rs2_q    <= '0;
      rd3_q    <= '0;
      sr3_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
      vld_q    <= vld_d;
      fr1_q    <= fr1_d;
      fr2_q    <= fr2_d;
      fr3_q    <= fr3_d;
      tr2_q    <= tr2_d;
      tr3_q    <= tr3_d;
      st2_q    <= st2_d;
      st3_q    <= st3_d;
      rs2_q    <= rs2_d;
      rd3_q    <= rd3_d;
      sr3_q    <= sr3_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_ready          = en & ~i_reset;
  assign o_valid          = vld_q[2];
  assign o_diffFR         = fr3_q;
  assign o_diff_trunc_sat = tr3_q;
  assign o_diff_round_sat = rd3_q;
  assign o_sat_trunc      = st3_q;
  assign o_sat_round      = sr3_q;
  assign o_sat_sticky     = sticky_q;
  assign o_sat_cnt        = cnt_q;

endmodule

// File: tb/tb_fxp_sub_pipe.sv
// Directed bench for fxp_sub_pipe: vector table with hand-computed results,
// then stall, mid-stream reset and counter saturation/clear sequences.
module tb_fxp_sub_pipe
  import fxp_pkg::*;
;

  logic                       i_clock = 1'b0;
  logic                       i_reset = 1'b1;
  logic                       i_valid = 1'b0;
  logic                       o_ready;
  logic [DEF_NB_IN_A-1:0]     i_A = '0;
  logic [DEF_NB_IN_B-1:0]     i_B = '0;
  logic                       o_valid;
  logic                       i_ready = 1'b1;
  logic [NB_O_FR-1:0]         o_diffFR;
  logic [DEF_NB_OUT-1:0]      o_diff_trunc_sat;
  logic [DEF_NB_O_ROUND-1:0]  o_diff_round_sat;
  logic                       o_sat_trunc;
  logic                       o_sat_round;
  logic                       i_clr = 1'b0;
  logic                       o_sat_sticky;
  logic [DEF_NB_CNT-1:0]      o_sat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fxp_sub_pipe dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_A              (i_A),
    .i_B              (i_B),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_diffFR         (o_diffFR),
    .o_diff_trunc_sat (o_diff_trunc_sat),
    .o_diff_round_sat (o_diff_round_sat),
    .o_sat_trunc      (o_sat_trunc),
    .o_sat_round      (o_sat_round),
    .i_clr            (i_clr),
    .o_sat_sticky     (o_sat_sticky),
    .o_sat_cnt        (o_sat_cnt)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [15:0] a;
    logic [11:0] b;
    logic [16:0] fr;
    logic [10:0] tr;
    logic [8:0]  rd;
    logic        st;
    logic        sr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          idx_in;
    int          got;
    int          seen;
    logic        held;
    logic        acc_in;
    logic        acc_out;
    logic [16:0] hold_val;

    // a, b, diffFR, trunc, round, sat_trunc, sat_round, counter after transfer
    vecs[0]  = '{16'h2000, 12'h200, 17'h01000, 11'h100, 9'h040, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{16'h6000, 12'h200, 17'h05000, 11'h3FF, 9'h0FF, 1'b1, 1'b1, 8'd1};
    vecs[2]  = '{16'h8000, 12'h400, 17'h16000, 11'h400, 9'h100, 1'b1, 1'b1, 8'd2};
    vecs[3]  = '{16'h0060, 12'h000, 17'h00060, 11'h006, 9'h002, 1'b0, 1'b0, 8'd2};
    vecs[4]  = '{16'h3FFF, 12'h000, 17'h03FFF, 11'h3FF, 9'h0FF, 1'b0, 1'b1, 8'd3};
    vecs[5]  = '{16'h0000, 12'h200, 17'h1F000, 11'h700, 9'h1C0, 1'b0, 1'b0, 8'd3};
    vecs[6]  = '{16'h0020, 12'h000, 17'h00020, 11'h002, 9'h001, 1'b0, 1'b0, 8'd3};
    vecs[7]  = '{16'h001F, 12'h000, 17'h0001F, 11'h001, 9'h000, 1'b0, 1'b0, 8'd3};
    vecs[8]  = '{16'hFFE0, 12'h000, 17'h1FFE0, 11'h7FE, 9'h000, 1'b0, 1'b0, 8'd3};
    vecs[9]  = '{16'h0000, 12'h800, 17'h04000, 11'h3FF, 9'h0FF, 1'b1, 1'b1, 8'd4};
    vecs[10] = '{16'h7FFF, 12'h800, 17'h0BFFF, 11'h3FF, 9'h0FF, 1'b1, 1'b1, 8'd5};
    vecs[11] = '{16'h8000, 12'h7FF, 17'h14008, 11'h400, 9'h100, 1'b1, 1'b1, 8'd6};
    vecs[12] = '{16'hC000, 12'h000, 17'h1C000, 11'h400, 9'h100, 1'b0, 1'b0, 8'd6};

    // Reset state
    repeat (3) @(negedge i_clock);
    check("rst_ready_low", 64'(o_ready), 64'd0);
    check("rst_outputs", {o_valid, o_diffFR, o_diff_trunc_sat, o_diff_round_sat,
                          o_sat_trunc, o_sat_round, o_sat_sticky, o_sat_cnt}, 64'd0);
    i_reset = 1'b0;
    #1;
    check("rst_ready_high", 64'(o_ready), 64'd1);

    // Single transfers through the table
    for (int i = 0; i < 13; i++) begin
      @(negedge i_clock);
      i_A = vecs[i].a;
      i_B = vecs[i].b;
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 10) begin
        @(negedge i_clock);
        lat++;
      end
      check($sformatf("lat%0d", i), 64'(lat), 64'd3);
      check($sformatf("vec%0d", i),
            {o_diffFR, o_diff_trunc_sat, o_diff_round_sat, o_sat_trunc, o_sat_round},
            {vecs[i].fr, vecs[i].tr, vecs[i].rd, vecs[i].st, vecs[i].sr});
      @(posedge i_clock);
      @(negedge i_clock);
      check($sformatf("cnt%0d", i), {o_sat_sticky, o_sat_cnt},
            {(vecs[i].cnt != 8'd0), vecs[i].cnt});
    end

    // Stream of 5 with a 4-cycle consumer stall
    idx_in = 0;
    got = 0;
    held = 1'b0;
    hold_val = '0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      @(negedge i_clock);
      i_ready = !(cyc >= 5 && cyc < 9);
      i_valid = (idx_in < 5);
      i_A = 16'((idx_in + 1) * 256);
      i_B = '0;
      #1;
      acc_in  = i_valid && o_ready;
      acc_out = o_valid && i_ready;
      if (o_valid && !i_ready) begin
        if (held) check("stall_hold", 64'(o_diffFR), 64'(hold_val));
        held = 1'b1;
        hold_val = o_diffFR;
      end else begin
        held = 1'b0;
      end
      if (acc_out) begin
        check($sformatf("stream%0d", got), {o_diffFR, o_diff_trunc_sat},
              {17'((got + 1) * 256), 11'((got + 1) * 16)});
        got++;
      end
      @(posedge i_clock);
      if (acc_in) idx_in++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    check("stream_count", 64'(got), 64'd5);
    seen = 0;
    repeat (4) begin
      @(negedge i_clock);
      if (o_valid) seen++;
    end
    check("stream_extra", 64'(seen), 64'd0);

    // Asynchronous reset with two operations in flight
    @(negedge i_clock);
    i_A = 16'h2000;
    i_B = 12'h200;
    i_valid = 1'b1;
    @(negedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    check("midrst_flush", {o_valid, o_diffFR, o_sat_sticky, o_sat_cnt}, 64'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge i_clock);
      if (o_valid) seen++;
    end
    check("midrst_discard", 64'(seen), 64'd0);

    // Counter saturation and clear priority
    @(negedge i_clock);
    i_A = 16'h6000;
    i_B = 12'h200;
    i_valid = 1'b1;
    repeat (270) @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    check("cnt_cap", {o_sat_sticky, o_sat_cnt}, {1'b1, 8'hFF});
    i_clr = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_clr = 1'b0;
    check("clr_prio", {o_sat_sticky, o_sat_cnt}, 64'd0);
    @(posedge i_clock);
    @(negedge i_clock);
    check("cnt_after_clr", {o_sat_sticky, o_sat_cnt}, {1'b1, 8'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
